// File: rtl/prf_busy_table.sv
// Physical register busy table: tracks pending results, answers source readiness
// for a rename group with intra-group dependency and writeback bypass.
module prf_busy_table #(
    parameter int unsigned RENAME_WIDTH = 4,
    parameter int unsigned WB_WIDTH     = 4,
    parameter int unsigned PRF_SIZE     = 64,
    parameter int unsigned PRF_IDX      = 6
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             alloc_en,
    input  logic [RENAME_WIDTH-1:0]          alloc_valid,
    input  logic [RENAME_WIDTH*PRF_IDX-1:0]  alloc_prd,
    input  logic [RENAME_WIDTH*PRF_IDX-1:0]  prs1,
    input  logic [RENAME_WIDTH*PRF_IDX-1:0]  prs2,
    input  logic [WB_WIDTH-1:0]              wb_valid,
    input  logic [WB_WIDTH*PRF_IDX-1:0]      wb_prd,
    input  logic                             recover,
    input  logic [PRF_SIZE-1:0]              recover_free,
    output logic [RENAME_WIDTH-1:0]          rs1_ready,
    output logic [RENAME_WIDTH-1:0]          rs2_ready,
    output logic [PRF_IDX:0]                 busy_count
);

    localparam int unsigned CNT_W = PRF_IDX + 1;

    logic [PRF_SIZE-1:0] busy_q, busy_d;
    logic [CNT_W-1:0]    busy_count_q, busy_count_d;

    // Readiness of one source as seen by rename slot 'slot'.
    function automatic logic src_ready(
        input logic [PRF_IDX-1:0]              src,
        input int unsigned                     slot,
        input logic [RENAME_WIDTH-1:0]         av,
        input logic [RENAME_WIDTH*PRF_IDX-1:0] ap,
        input logic [WB_WIDTH-1:0]             wv,
        input logic [WB_WIDTH*PRF_IDX-1:0]     wp,
        input logic [PRF_SIZE-1:0]             busy
    );
        logic dep;
        logic byp;
        dep = 1'b0;
        byp = 1'b0;
        for (int unsigned k = 0; k < RENAME_WIDTH; k++) begin
            if (k < slot && av[k] && ap[k*PRF_IDX +: PRF_IDX] == src) dep = 1'b1;
        end
        for (int unsigned j = 0; j < WB_WIDTH; j++) begin
            if (wv[j] && wp[j*PRF_IDX +: PRF_IDX] == src) byp = 1'b1;
        end
        if (src == '0)  return 1'b1;
        else if (dep)   return 1'b0;
        else if (byp)   return 1'b1;
        else            return ~busy[src];
    endfunction

    always_comb begin
        rs1_ready = '0;
        rs2_ready = '0;
        for (int unsigned i = 0; i < RENAME_WIDTH; i++) begin
            rs1_ready[i] = src_ready(prs1[i*PRF_IDX +: PRF_IDX], i, alloc_valid, alloc_prd,
                                     wb_valid, wb_prd, busy_q);
            rs2_ready[i] = src_ready(prs2[i*PRF_IDX +: PRF_IDX], i, alloc_valid, alloc_prd,
                                     wb_valid, wb_prd, busy_q);
        end
    end

    // Clears first, then sets, so an allocation beats a same-cycle writeback.
    always_comb begin
        busy_d = busy_q;
        for (int unsigned j = 0; j < WB_WIDTH; j++) begin
            if (wb_valid[j]) busy_d[wb_prd[j*PRF_IDX +: PRF_IDX]] = 1'b0;
        end
        if (recover) begin
            busy_d = busy_d & ~recover_free;
        end else if (alloc_en) begin
            for (int unsigned i = 0; i < RENAME_WIDTH; i++) begin
                if (alloc_valid[i] && alloc_prd[i*PRF_IDX +: PRF_IDX] != '0)
                    busy_d[alloc_prd[i*PRF_IDX +: PRF_IDX]] = 1'b1;
            end
        end
        busy_d[0] = 1'b0;
    end

    // Count the next vector so the registered count tracks busy_q with no lag.
    always_comb begin
        busy_count_d = '0;
        for (int unsigned k = 0; k < PRF_SIZE; k++) begin
            busy_count_d = busy_count_d + CNT_W'(busy_d[k]);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            busy_q       <= '0;
            busy_count_q <= '0;
        end else begin
            busy_q       <= busy_d;
            busy_count_q <= busy_count_d;
        end
    end

    assign busy_count = busy_count_q;

endmodule

// File: tb/tb_prf_busy_table.sv
// Scoreboard bench for prf_busy_table: stimulus queues expectations tagged with
// the cycle they apply to; a negedge monitor pops and compares them.
module tb_prf_busy_table;

    localparam int unsigned RW = 4;
    localparam int unsigned WW = 4;
    localparam int unsigned PS = 64;
    localparam int unsigned P  = 6;

    localparam int K_RS1 = 0;
    localparam int K_RS2 = 1;
    localparam int K_CNT = 2;

    logic             clock = 1'b0;
    logic             reset;
    logic             alloc_en;
    logic [RW-1:0]    alloc_valid;
    logic [RW*P-1:0]  alloc_prd;
    logic [RW*P-1:0]  prs1;
    logic [RW*P-1:0]  prs2;
    logic [WW-1:0]    wb_valid;
    logic [WW*P-1:0]  wb_prd;
    logic             recover;
    logic [PS-1:0]    recover_free;
    logic [RW-1:0]    rs1_ready;
    logic [RW-1:0]    rs2_ready;
    logic [P:0]       busy_count;

    prf_busy_table #(.RENAME_WIDTH(RW), .WB_WIDTH(WW), .PRF_SIZE(PS), .PRF_IDX(P)) dut (
        .clock        (clock),
        .reset        (reset),
        .alloc_en     (alloc_en),
        .alloc_valid  (alloc_valid),
        .alloc_prd    (alloc_prd),
        .prs1         (prs1),
        .prs2         (prs2),
        .wb_valid     (wb_valid),
        .wb_prd       (wb_prd),
        .recover      (recover),
        .recover_free (recover_free),
        .rs1_ready    (rs1_ready),
        .rs2_ready    (rs2_ready),
        .busy_count   (busy_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        int cyc;
        int kind;
        int idx;
        int exp;
    } exp_t;

    exp_t  q[$];
    string nq[$];
    int    cyc = 0;
    int    checks = 0;
    int    errors = 0;

    always @(posedge clock) cyc <= cyc + 1;

    // Monitor: compare every expectation due in the current cycle.
    always @(negedge clock) begin
        exp_t  e;
        string nm;
        int    act;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e  = q.pop_front();
            nm = nq.pop_front();
            if (e.kind == K_RS1)      act = int'(rs1_ready[e.idx]);
            else if (e.kind == K_RS2) act = int'(rs2_ready[e.idx]);
            else                      act = int'(busy_count);
            checks++;
            if (e.cyc != cyc || act != e.exp) begin
                errors++;
                $display("FAIL %s (cycle %0d): got %0d expected %0d", nm, e.cyc, act, e.exp);
            end
        end
    end

    task automatic chk(input int kind, input int idx, input int v, input string nm);
        q.push_back('{cyc, kind, idx, v});
        nq.push_back(nm);
    endtask

    task automatic clr();
        reset        = 1'b0;
        alloc_en     = 1'b0;
        alloc_valid  = '0;
        alloc_prd    = '0;
        prs1         = '0;
        prs2         = '0;
        wb_valid     = '0;
        wb_prd       = '0;
        recover      = 1'b0;
        recover_free = '0;
    endtask

    task automatic next();
        @(posedge clock);
        #1;
        clr();
    endtask

    task automatic al(input int s, input int p);
        alloc_valid[s]     = 1'b1;
        alloc_prd[s*P +: P] = P'(p);
    endtask

    task automatic s1(input int s, input int p);
        prs1[s*P +: P] = P'(p);
    endtask

    task automatic s2(input int s, input int p);
        prs2[s*P +: P] = P'(p);
    endtask

    task automatic wb(input int j, input int p);
        wb_valid[j]      = 1'b1;
        wb_prd[j*P +: P] = P'(p);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        clr();
        reset = 1'b1;
        next();
        // Ready during reset follows the (cleared) vector
        reset = 1'b1; s1(0, 5);
        chk(K_RS1, 0, 1, "rst_rs1_5");
        next();
        s1(0, 5);
        chk(K_RS1, 0, 1, "post_rst_rs1_5");
        chk(K_CNT, 0, 0, "post_rst_cnt");
        next();
        alloc_en = 1'b1; al(0, 7);
        chk(K_CNT, 0, 0, "pre_alloc7_cnt");
        next();
        s1(0, 7);
        chk(K_RS1, 0, 0, "busy7_rs1");
        chk(K_CNT, 0, 1, "alloc7_cnt");
        next();
        s1(0, 7); wb(0, 7);
        chk(K_RS1, 0, 1, "bypass7_rs1");
        chk(K_CNT, 0, 1, "wb7_cnt_still1");
        next();
        s1(0, 7);
        chk(K_RS1, 0, 1, "cleared7_rs1");
        chk(K_CNT, 0, 0, "cleared7_cnt");
        next();
        // Intra-group dependency outranks bypass; set wins over clear on reg 9
        alloc_en = 1'b1; al(0, 9); wb(0, 9);
        s2(1, 9); s2(0, 9); s1(1, 9);
        chk(K_RS2, 1, 0, "dep9_rs2_slot1");
        chk(K_RS1, 1, 0, "dep9_rs1_slot1");
        chk(K_RS2, 0, 1, "own9_rs2_slot0");
        next();
        s2(0, 9);
        al(0, 30); s1(0, 30); s1(1, 30);
        chk(K_RS2, 0, 0, "busy9_rs2");
        chk(K_CNT, 0, 1, "setwins9_cnt");
        chk(K_RS1, 0, 1, "own_slot30_rs1");
        chk(K_RS1, 1, 0, "dep30_no_alloc_en");
        next();
        wb(1, 9); wb(2, 9); s2(3, 9);
        chk(K_RS2, 3, 1, "dupwb9_bypass");
        chk(K_CNT, 0, 1, "dupwb9_cnt_still1");
        next();
        alloc_en = 1'b1; al(0, 10); al(1, 11);
        chk(K_CNT, 0, 0, "dupwb9_cnt0");
        next();
        // Recovery drops the allocation of 12 and frees 10/11
        recover = 1'b1; recover_free[10] = 1'b1; recover_free[11] = 1'b1;
        alloc_en = 1'b1; al(0, 12);
        s1(0, 10);
        chk(K_CNT, 0, 2, "alloc10_11_cnt");
        chk(K_RS1, 0, 0, "busy10_rs1");
        next();
        s1(0, 10); s1(1, 11); s1(2, 12);
        chk(K_RS1, 0, 1, "rec_free10");
        chk(K_RS1, 1, 1, "rec_free11");
        chk(K_RS1, 2, 1, "rec_noalloc12");
        chk(K_CNT, 0, 0, "rec_cnt");
        next();
        alloc_en = 1'b1; al(0, 0); s1(0, 0); s1(1, 0);
        chk(K_RS1, 0, 1, "zero_src_slot0");
        chk(K_RS1, 1, 1, "zero_src_over_dep");
        next();
        alloc_en = 1'b1; al(0, 20); wb(0, 20);
        chk(K_CNT, 0, 0, "alloc0_cnt");
        next();
        reset = 1'b1; alloc_en = 1'b1; al(0, 21);
        s1(0, 20);
        chk(K_CNT, 0, 1, "setclr20_cnt");
        chk(K_RS1, 0, 0, "setclr20_busy");
        next();
        s1(0, 21); s1(1, 20);
        chk(K_CNT, 0, 0, "rst_over_alloc21_cnt");
        chk(K_RS1, 0, 1, "rst_21_ready");
        chk(K_RS1, 1, 1, "rst_20_ready");
        next();
        alloc_en = 1'b1; al(0, 40); al(1, 41); al(2, 42); al(3, 43);
        next();
        s2(3, 43); s2(2, 41); wb(0, 40); wb(3, 41);
        chk(K_CNT, 0, 4, "alloc4_cnt");
        chk(K_RS2, 3, 0, "busy43_rs2");
        chk(K_RS2, 2, 1, "bypass41_rs2");
        next();
        s1(0, 40); s1(1, 42);
        chk(K_CNT, 0, 2, "wb2_cnt");
        chk(K_RS1, 0, 1, "free40_rs1");
        chk(K_RS1, 1, 0, "busy42_rs1");
        next();
        next();
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/prf_busy_table.md
PRF_BUSY_TABLE -- requirements
Module: prf_busy_table

Interface
REQ-001 The block SHALL have parameter RENAME_WIDTH, default 4, meaning rename group width.
REQ-002 The block SHALL have parameter WB_WIDTH, default 4, meaning writeback ports.
REQ-003 The block SHALL have parameter PRF_SIZE, default 64, meaning physical integer registers.
REQ-004 The block SHALL have parameter PRF_IDX, default 6, meaning index width, equal to log2(PRF_SIZE).
REQ-005 The block SHALL have port clock, input, 1 bit, the system clock; all state updates on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-007 The block SHALL have port alloc_en, input, 1 bit, meaning the rename group fires this cycle (not stalled and allocatable).
REQ-008 The block SHALL have port alloc_valid, input, RENAME_WIDTH bits, meaning slot i allocates a destination.
REQ-009 The block SHALL have port alloc_prd, input, RENAME_WIDTH x PRF_IDX bits, meaning the new physical destination per slot.
REQ-010 The block SHALL have ports prs1 and prs2, input, RENAME_WIDTH x PRF_IDX bits each, meaning renamed sources per slot.
REQ-011 The block SHALL have port wb_valid, input, WB_WIDTH bits, meaning writeback port j completes.
REQ-012 The block SHALL have port wb_prd, input, WB_WIDTH x PRF_IDX bits, meaning the register produced on port j.
REQ-013 The block SHALL have port recover, input, 1 bit, meaning a mispredict flush is in progress this cycle.
REQ-014 The block SHALL have port recover_free, input, PRF_SIZE bits, meaning registers returned to the free list by recovery.
REQ-015 The block SHALL have ports rs1_ready and rs2_ready, output, RENAME_WIDTH bits each, meaning the source value is available.
REQ-016 The block SHALL have port busy_count, output, PRF_IDX+1 bits, registered population count of busy bits.

Function
REQ-017 The block SHALL hold a PRF_SIZE-bit busy vector; bit 1 means the value is pending.
REQ-018 Physical register 0 SHALL always read ready and SHALL never be set busy.
REQ-019 When alloc_en=1 and recover=0, each slot with alloc_valid[i]=1 and alloc_prd[i]!=0 SHALL set busy[alloc_prd[i]] at the next edge.
REQ-020 Each wb_valid[j]=1 SHALL clear busy[wb_prd[j]] at the next edge.
REQ-021 If a set and a clear target the same register in one cycle, the set SHALL win.
REQ-022 When recover=1: allocations SHALL be ignored; writeback clears SHALL still apply; every bit with recover_free=1 SHALL be cleared at the next edge.
REQ-023 Each rsN_ready[i] SHALL be combinational, computed from the source, the current busy vector and the same-cycle writeback ports and allocations, as follows.
REQ-024 rsN_ready[i] SHALL be 1 if the source is 0.
REQ-025 Otherwise rsN_ready[i] SHALL be 0 if an earlier slot k<i in the same group has alloc_valid[k]=1 and alloc_prd[k]==source (intra-group dependency; this rule outranks the writeback bypass).
REQ-026 Otherwise rsN_ready[i] SHALL be 1 if any same-cycle wb_valid[j]=1 has wb_prd[j]==source (writeback bypass).
REQ-027 Otherwise rsN_ready[i] SHALL equal the inverse of busy[source].
REQ-028 A slot's own alloc_prd SHALL NOT affect its own source readiness.
REQ-029 Ready outputs SHALL be produced regardless of alloc_en; the consumer qualifies them.
REQ-030 busy_count SHALL equal the popcount of the busy vector as it stands after each edge, with zero-cycle lag relative to the busy register.
REQ-031 Duplicate writeback indices in one cycle SHALL be legal and clear the bit once.

Reset
REQ-032 On reset=1 at an edge, all busy bits SHALL become 0 and busy_count SHALL become 0.
REQ-033 Reset SHALL override recover, alloc_en and writeback in the same cycle.
REQ-034 During reset, rsN_ready SHALL still follow REQ-024 to REQ-027 against the cleared vector.

Verification
REQ-035 Test: reset, then prs1[0]=5 -> rs1_ready[0]=1, busy_count=0.
REQ-036 Test: alloc_en=1, alloc_valid=0001, alloc_prd[0]=7; next cycle prs1[0]=7 -> rs1_ready[0]=0, busy_count=1; wb_valid[0]=1, wb_prd[0]=7 in that cycle -> rs1_ready[0]=1 (bypass); the following cycle busy_count=0.
REQ-037 Test: same group with alloc_prd[0]=9 and prs2[1]=9 -> rs2_ready[1]=0, also with wb_prd[0]=9 valid; prs2[0]=9 -> follows busy[9].
REQ-038 Test: alloc registers 10 and 11, then recover=1 with recover_free bits 10 and 11 set plus alloc_en=1, alloc_prd[0]=12 -> next cycle regs 10, 11 and 12 are all ready, busy_count=0.
REQ-039 Test: alloc_prd=0 with alloc_valid=1 -> busy_count unchanged, prs1=0 ready.
REQ-040 Test: set and clear of register 20 in the same cycle -> busy[20]=1 next cycle; reset asserted together with alloc of register 21 -> busy_count=0.
